serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
Bit-serial subtractor: the counterpart to the team's 1-bit registered adder. It accepts two WIDTH-bit operands in parallel and computes a-b LSB-first, one bit per clock, using a registered borrow. It presents the difference both serially, as it is produced, and as a parallel word with a final borrow flag. It is used wherever area matters more than latency, and as a checker against the serial adder path (a+b-b=a).

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
start  input  1  request; sampled on the rising clk edge, accepted only when not busy
a  input  WIDTH  minuend, captured on the accepting edge
b  input  WIDTH  subtrahend, captured on the accepting edge
busy  output  1  high while a subtraction is in progress
sdiff  output  1  serial difference bit, LSB-first
sdiff_vld  output  1  qualifies sdiff, one bit per cycle
diff  output  WIDTH  parallel result a-b mod 2^WIDTH
bout  output  1  final borrow; 1 means a<b (unsigned)
done  output  1  single-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous and active-low. Assertion immediately forces state=IDLE. All registers clear, and busy, sdiff, sdiff_vld, diff, bout and done are all 0. Release is synchronous to clk.
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: one-cycle completion state, done=1.
- Transitions:
  - IDLE, start=1 -> RUN. On that edge, a and b are loaded into shift registers, the borrow register br=0 and the bit counter cnt=0.
  - RUN, cnt==WIDTH-1 -> DONE. Otherwise, stay in RUN and increment cnt.
  - DONE, start=1 -> RUN (back-to-back, reloads as from IDLE). DONE, start=0 -> IDLE.
- Per-bit rule in RUN, with ai/bi taken from the shift register LSBs:
  - d = ai ^ bi ^ br
  - br_next = (~ai & bi) | (~(ai ^ bi) & br)
  - d shifts into the MSB of the result register. The operand registers shift right by 1.
- Serial outputs: sdiff and sdiff_vld are registered. Bit i appears in the cycle after RUN processes it, so sdiff_vld is high for exactly WIDTH consecutive cycles starting one cycle after the accepting edge.
- Latency: with start accepted at edge t0:
  - busy=1 for cycles t0+1 .. t0+WIDTH.
  - At edge t0+WIDTH+1, done=1 for one cycle, busy=0, and diff and bout are updated.
  - Total WIDTH+1 cycles from accept to done.
- Hold behaviour: diff and bout hold their last result until the next completion. They are not cleared on start.
- start while busy=1 is ignored: the operands are not re-sampled and the operation in progress is unaffected.
- Operands are sampled only on the accepting edge. Later changes to a or b have no effect on the current operation.
- Wrap: the result is modulo 2^WIDTH. bout is the borrow out of the MSB.
- Reset mid-RUN aborts the operation. No done pulse is issued, and all outputs read 0 after reset.

Test Plan:
1. Reset: hold rstn=0 with start=1 and random a/b -> all outputs 0. Release, keep start=0 for 10 cycles -> busy=0, done never pulses.
2. WIDTH=8, a=5, b=3, single start pulse:
   - busy high for 8 cycles.
   - sdiff sequence LSB-first 0,1,0,0,0,0,0,0.
   - done pulse at accept+9 with diff=0x02, bout=0.
3. a=0x03, b=0x05 -> diff=0xFE, bout=1. Also a=0x00, b=0x00 -> diff=0x00, bout=0. Also a=0xFF, b=0x00 -> diff=0xFF, bout=0. Also a=0x00, b=0xFF -> diff=0x01, bout=1.
4. Pulse start again at cycle 3 of an operation, with different a/b -> ignored. The first result is unchanged and exactly one done pulse is issued.
5. Back-to-back: assert start in the DONE cycle with a=0x10, b=0x01 -> a new RUN begins with no IDLE gap. The second done arrives 9 cycles after the first with diff=0x0F. The first result's diff is held until then.
6. Reset mid-RUN (rstn=0 at cycle 4) -> busy, done, diff and bout are 0 immediately. After release, a fresh 0x80-0x01 produces diff=0x7F, bout=0. Self-check all cases against a reference model over 200 random operand pairs.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a-b computed LSB-first, one bit per clock with a registered borrow.
// The difference is streamed on sdiff and also presented as a parallel word with a final borrow.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             sdiff,
  output logic             sdiff_vld,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one difference bit per cycle, cnt counts processed bits
  // DONE  | single-cycle completion, diff/bout just updated; start here reloads
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic             ai, bi, d, br_nxt;

  assign ai      = sh_a[0];
  assign bi      = sh_b[0];
  assign d       = ai ^ bi ^ br;
  assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
  assign last    = (cnt == CW'(WIDTH - 1));
  // The newest bit is not registered yet, so the full word is it plus the bits so far.
  assign res_nxt = {d, res_q};

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_a      <= '0;
      sh_b      <= '0;
      res_q     <= '0;
      br        <= 1'b0;
      cnt       <= '0;
      sdiff     <= 1'b0;
      sdiff_vld <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
    end else begin
      sdiff_vld <= (state == RUN);
      sdiff     <= (state == RUN) & d;
      if (accept) begin
        sh_a  <= a;
        sh_b  <= b;
        br    <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        sh_a  <= sh_a >> 1;
        sh_b  <= sh_b >> 1;
        res_q <= res_nxt[WIDTH-1:1];
        br    <= br_nxt;
        cnt   <= cnt + CW'(1);
        if (last) begin
          diff <= res_nxt;
          bout <= br_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_sub;

  localparam int W = 8;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, sdiff, sdiff_vld, bout, done;
  logic [W-1:0] diff;

  int total = 0;
  int bad   = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .a(a), .b(b),
    .busy(busy), .sdiff(sdiff), .sdiff_vld(sdiff_vld),
    .diff(diff), .bout(bout), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  // Launch one operation from IDLE/DONE and follow it to its done cycle.
  // lat counts cycles after the accepting edge; returns inside the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       output logic [W-1:0] sbits, output int nvld,
                       output int nbusy, output int lat);
    start = 1'b1; a = ta; b = tb_v;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    sbits = '0; nvld = 0; nbusy = 0; lat = 1;
    while (lat < 40) begin
      if (busy) nbusy++;
      if (sdiff_vld) begin
        if (nvld < W) sbits[nvld] = sdiff;
        nvld++;
      end
      if (done) break;
      step();
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    logic [W-1:0] sbits;
    int nvld, nbusy, lat;
    do_op(ta, tb_v, sbits, nvld, nbusy, lat);
    total++;
    if (lat !== W + 1) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, W + 1);
    end
    total++;
    if (diff !== ref_diff(ta, tb_v)) begin
      bad++; $display("FAIL %s diff a=%h b=%h got=%h want=%h", name, ta, tb_v, diff, ref_diff(ta, tb_v));
    end
    total++;
    if (bout !== ref_bout(ta, tb_v)) begin
      bad++; $display("FAIL %s bout a=%h b=%h got=%b want=%b", name, ta, tb_v, bout, ref_bout(ta, tb_v));
    end
    total++;
    if (sbits !== ref_diff(ta, tb_v) || nvld !== W) begin
      bad++; $display("FAIL %s serial got=%h/%0d want=%h/%0d", name, sbits, nvld, ref_diff(ta, tb_v), W);
    end
    total++;
    if (nbusy !== W) begin
      bad++; $display("FAIL %s busy_cycles got=%0d want=%0d", name, nbusy, W);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b1; a = W'($urandom); b = W'($urandom);
    repeat (3) step();
    total++;
    if ({busy, sdiff, sdiff_vld, diff, bout, done} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0", {busy, sdiff, sdiff_vld, diff, bout, done});
    end
    start = 1'b0;
    rstn  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL reset_idle cycle=%0d busy=%b done=%b want 0/0", i, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] sbits;
    int nvld, nbusy, lat;
    do_op(8'd5, 8'd3, sbits, nvld, nbusy, lat);
    total++;
    if (nbusy !== 8) begin bad++; $display("FAIL basic_busy got=%0d want=8", nbusy); end
    total++;
    if (sbits !== 8'b0000_0010 || nvld !== 8) begin
      bad++; $display("FAIL basic_sdiff got=%b/%0d want=00000010/8", sbits, nvld);
    end
    total++;
    if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
    total++;
    if (diff !== 8'h02 || bout !== 1'b0) begin
      bad++; $display("FAIL basic_result got=%h/%b want=02/0", diff, bout);
    end
    step();
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
  endtask

  task automatic test_corners();
    logic [W-1:0] ca [4] = '{8'h03, 8'h00, 8'hFF, 8'h00};
    logic [W-1:0] cb [4] = '{8'h05, 8'h00, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      check_op($sformatf("corner%0d", i), ca[i], cb[i]);
      step();
    end
  endtask

  task automatic test_ignore();
    int ndone = 0;
    start = 1'b1; a = 8'h40; b = 8'h11;
    step();
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'h01; b = 8'h77; end
      else        start = 1'b0;
      if (done) begin
        ndone++;
        total++;
        if (diff !== 8'h2F || bout !== 1'b0) begin
          bad++; $display("FAIL ignore_result got=%h/%b want=2f/0", diff, bout);
        end
      end
      step();
    end
    start = 1'b0;
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] sbits;
    int nvld, nbusy, lat, gap;
    do_op(8'h20, 8'h05, sbits, nvld, nbusy, lat);
    total++;
    if (diff !== 8'h1B) begin bad++; $display("FAIL b2b_first got=%h want=1b", diff); end
    start = 1'b1; a = 8'h10; b = 8'h01;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap busy=%b want=1", busy); end
    gap = 1;
    while (!done && gap < 40) begin
      total++;
      if (diff !== 8'h1B) begin bad++; $display("FAIL b2b_hold got=%h want=1b", diff); end
      step();
      gap++;
    end
    total++;
    if (gap !== 9) begin bad++; $display("FAIL b2b_spacing got=%0d want=9", gap); end
    total++;
    if (diff !== 8'h0F || bout !== 1'b0) begin
      bad++; $display("FAIL b2b_second got=%h/%b want=0f/0", diff, bout);
    end
    step();
  endtask

  task automatic test_mid_reset();
    start = 1'b1; a = 8'hC3; b = 8'h14;
    step();
    start = 1'b0;
    repeat (3) step();
    rstn = 1'b0;
    #1;
    total++;
    if ({busy, done, diff, bout, sdiff_vld} !== '0) begin
      bad++; $display("FAIL midreset_clear got=%b/%b/%h/%b/%b want all 0", busy, done, diff, bout, sdiff_vld);
    end
    step();
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL midreset_no_done cycle=%0d got=1 want=0", i); end
      step();
    end
    check_op("after_reset", 8'h80, 8'h01);
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      check_op("rand", ra, rb);
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    test_reset();
    test_basic();
    test_corners();
    test_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
